// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module : addsub_pkg
// Brief  : Shared types for the multi-cycle add/subtract unit:
//          FSM state encoding and the result flag bundle.
// Rev    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

  // Unit state: waiting for operands, walking slices, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

  // Result flags captured together with the final slice.
  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } addsub_flags_t;

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/add_chunk.sv
`default_nettype none
// ============================================================================
// Module : add_chunk
// Brief  : Combinational CHUNK-bit adder with carry in and carry out.
//          A single instance is time-shared across all slices of an operation.
// Ports  : a, b  - slice operands (CHUNK bits)
//          cin   - carry into the slice
//          sum   - slice result (CHUNK bits)
//          cout  - carry out of the slice MSB
// Rev    : 1.0 - initial release
// ============================================================================
module add_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule : add_chunk
`default_nettype wire

// File: rtl/addsub_seq.sv
`default_nettype none
// ============================================================================
// Module : addsub_seq
// Brief  : Multi-cycle add/subtract. Operands are processed CHUNK bits per
//          cycle over a registered carry, so a WIDTH-bit operation takes
//          WIDTH/CHUNK cycles on one narrow adder. Valid/ready on both sides.
// Ports  : clk, reset           - clock, synchronous active-high reset
//          in_valid/in_ready    - operand handshake (a, b, sub)
//          a, b                 - WIDTH-bit operands
//          sub                  - 0: a+b, 1: a-b
//          out_valid/out_ready  - result handshake
//          sum                  - WIDTH-bit result modulo 2^WIDTH
//          cout, ovf, zero, neg - carry (no-borrow on sub), signed overflow,
//                                 zero result, result sign
// Rev    : 1.0 - initial release
// ============================================================================
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] C_LAST_IDX = CW'(NCHUNK - 1);

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_cfg
      $error("addsub_seq: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  addsub_state_t state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // already inverted for subtract
  logic [WIDTH-1:0] acc_q, acc_d;   // slices of the operation in flight
  logic [WIDTH-1:0] sum_q, sum_d;   // last delivered result
  addsub_flags_t    flags_q, flags_d;

  logic [CHUNK-1:0] slice_a, slice_b, slice_sum;
  logic             slice_cout;
  int               lsb;

  always_comb begin
    lsb     = CHUNK * int'(idx_q);
    slice_a = a_q[lsb +: CHUNK];
    slice_b = b_q[lsb +: CHUNK];
  end

  add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtract as a + ~b + 1: invert b here, seed the carry with 1.
          state_d = BUSY;
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
        end
      end
      BUSY: begin
        acc_d[lsb +: CHUNK] = slice_sum;
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == C_LAST_IDX) begin
          // Publish result and flags only on completion, so sum keeps the
          // previous result while an operation is in progress.
          state_d      = DONE;
          sum_d        = acc_d;
          flags_d.cout = slice_cout;
          flags_d.ovf  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (acc_d[WIDTH-1] != a_q[WIDTH-1]);
          flags_d.zero = (acc_d == '0);
          flags_d.neg  = acc_d[WIDTH-1];
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = flags_q.cout;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;

endmodule : addsub_seq
`default_nettype wire

// File: tb/tb_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_addsub_seq
// Brief  : Directed self-checking bench for addsub_seq in three
//          configurations: 32/16, 8/4 and 8/8 (WIDTH/CHUNK).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_addsub_seq;

  logic clk = 1'b0;
  logic rst;
  logic ordy;

  always #5 clk = ~clk;

  // 32-bit / 16-bit slices
  logic        iv32, ir32, ov32, sub32;
  logic [31:0] a32, b32, sum32;
  logic        co32, of32, z32, n32;

  // 8-bit inputs shared by both 8-bit configurations
  logic        iv8, sub8;
  logic [7:0]  a8, b8;
  logic        ir_4, ov_4, co_4, of_4, z_4, n_4;
  logic        ir_8, ov_8, co_8, of_8, z_8, n_8;
  logic [7:0]  sum_4, sum_8;

  addsub_seq #(.WIDTH(32), .CHUNK(16)) u_dut32 (
    .clk(clk), .reset(rst), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .sub(sub32), .out_valid(ov32), .out_ready(ordy),
    .sum(sum32), .cout(co32), .ovf(of32), .zero(z32), .neg(n32));

  addsub_seq #(.WIDTH(8), .CHUNK(4)) u_dut8_4 (
    .clk(clk), .reset(rst), .in_valid(iv8), .in_ready(ir_4),
    .a(a8), .b(b8), .sub(sub8), .out_valid(ov_4), .out_ready(ordy),
    .sum(sum_4), .cout(co_4), .ovf(of_4), .zero(z_4), .neg(n_4));

  addsub_seq #(.WIDTH(8), .CHUNK(8)) u_dut8_8 (
    .clk(clk), .reset(rst), .in_valid(iv8), .in_ready(ir_8),
    .a(a8), .b(b8), .sub(sub8), .out_valid(ov_8), .out_ready(ordy),
    .sum(sum_8), .cout(co_8), .ovf(of_8), .zero(z_8), .neg(n_8));

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One 32-bit operation from IDLE; flags are {cout, ovf, zero, neg}.
  task automatic run32(input string tag, input logic [31:0] a_i, input logic [31:0] b_i,
                       input logic s_i, input logic [31:0] exp_sum, input logic [3:0] exp_fl);
    int lat;
    a32 = a_i; b32 = b_i; sub32 = s_i; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    lat = 0;
    while (!ov32 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " lat"}, 64'(lat), 64'd2);
    chk({tag, " sum"}, {32'd0, sum32}, {32'd0, exp_sum});
    chk({tag, " flags"}, {60'd0, co32, of32, z32, n32}, {60'd0, exp_fl});
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk({tag, " back to idle"}, {62'd0, ir32, ov32}, 64'b10);
  endtask

  // One 8-bit operation on both 8-bit configurations at once.
  task automatic run8(input string tag, input logic [7:0] a_i, input logic [7:0] b_i,
                      input logic s_i, input logic [7:0] exp_sum, input logic [3:0] exp_fl);
    int lat4, lat8, n;
    a8 = a_i; b8 = b_i; sub8 = s_i; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat4 = -1; lat8 = -1; n = 0;
    while ((lat4 < 0 || lat8 < 0) && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (ov_4 && lat4 < 0) lat4 = n;
      if (ov_8 && lat8 < 0) lat8 = n;
    end
    chk({tag, " c4 lat"}, 64'(lat4), 64'd2);
    chk({tag, " c8 lat"}, 64'(lat8), 64'd1);
    chk({tag, " c4 sum"}, {56'd0, sum_4}, {56'd0, exp_sum});
    chk({tag, " c8 sum"}, {56'd0, sum_8}, {56'd0, exp_sum});
    chk({tag, " c4 flags"}, {60'd0, co_4, of_4, z_4, n_4}, {60'd0, exp_fl});
    chk({tag, " c8 flags"}, {60'd0, co_8, of_8, z_8, n_8}, {60'd0, exp_fl});
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk({tag, " idle"}, {60'd0, ir_4, ov_4, ir_8, ov_8}, 64'b1010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ordy = 1'b0;
    iv32 = 1'b0; a32 = '0; b32 = '0; sub32 = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready/valid 32", {62'd0, ir32, ov32}, 64'b10);
    chk("reset sum 32", {32'd0, sum32}, 64'd0);
    chk("reset flags 32", {60'd0, co32, of32, z32, n32}, 64'd0);
    chk("reset ready/valid 8", {60'd0, ir_4, ov_4, ir_8, ov_8}, 64'b1010);
    rst = 1'b0;

    // Basic arithmetic and flag corners.
    run32("carry cross", 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 4'b0000);
    run32("sub to zero", 32'h00000002, 32'h00000002, 1'b1, 32'h00000000, 4'b1010);
    run32("pos ovf",     32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b0101);
    run32("borrow",      32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 4'b0001);
    run32("neg+neg",     32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 4'b1001);
    run32("sub ovf",     32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 4'b1100);

    // Back-pressure in DONE while new operands are offered.
    a32 = 32'h12345678; b32 = 32'h11111111; sub32 = 1'b0; iv32 = 1'b1;
    @(posedge clk); #1;
    a32 = 32'h00000010; b32 = 32'h00000020; sub32 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("bp done", {63'd0, ov32}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp hold sum", {32'd0, sum32}, 64'h23456789);
      chk("bp hold flags/ready", {59'd0, co32, of32, z32, n32, ir32}, 64'd0);
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk("bp after handshake", {62'd0, ir32, ov32}, 64'b10);
    @(posedge clk); #1;
    iv32 = 1'b0;
    chk("bp second accept", {63'd0, ir32}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp second valid", {63'd0, ov32}, 64'd1);
    chk("bp second sum", {32'd0, sum32}, 64'hFFFFFFF0);
    chk("bp second flags", {60'd0, co32, of32, z32, n32}, 64'b0001);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;

    // Reset during BUSY aborts the operation.
    a32 = 32'h00000005; b32 = 32'h00000003; sub32 = 1'b0; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    chk("abort busy", {62'd0, ir32, ov32}, 64'b00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort ready/valid", {62'd0, ir32, ov32}, 64'b10);
    chk("abort sum", {32'd0, sum32}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort no stale", {63'd0, ov32}, 64'd0);
    end
    run32("after abort", 32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 4'b1000);

    // Narrow configurations: 2 slices and 1 slice.
    run8("ff+1", 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1010);
    run8("80-1", 8'h80, 8'h01, 1'b1, 8'h7F, 4'b1100);
    run8("5-7",  8'h05, 8'h07, 1'b1, 8'hFE, 4'b0001);
    run8("40+40", 8'h40, 8'h40, 1'b0, 8'h80, 4'b0101);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_addsub_seq
`default_nettype wire
